gigerx_frame_rd_ctrl: RTL



---
 rtl/gigerx_pkg.sv | 19 +
 rtl/gigerx_rdctrl_obuf.sv | 39 +++
 rtl/gigerx_frame_rd_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gigerx_pkg.sv
// gigerx_pkg: shared FSM states, byte-count field layout and word-count helper
// for the gigabit RX read path.
package gigerx_pkg;

    typedef enum logic [1:0] {IDLE, BCNT, DATA, DROP} rd_state_e;

    localparam int BC_ERR_BIT    = 15;
    localparam int BC_LEN_MSB    = 13;
    localparam int MAX_BYTES_DEF = 9600;
    localparam int WCNT_W        = 12;

    // number of 8-byte words covering a byte count, rounded up
    function automatic logic [WCNT_W-1:0] bc_words(input logic [BC_LEN_MSB:0] bytes);
        logic [BC_LEN_MSB+1:0] s;
        s = {1'b0, bytes} + (BC_LEN_MSB+2)'(7);
        return s[BC_LEN_MSB+1:3];
    endfunction

endpackage

// File: rtl/gigerx_rdctrl_obuf.sv
// gigerx_rdctrl_obuf: 2-entry output FIFO; the head drives the stream ports
// and reads as zero while empty.
module gigerx_rdctrl_obuf #(
    parameter int W = 69
) (
    input  logic         rdclk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         valid,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;

    always_ff @(posedge rdclk) begin
        if (reset) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (wr_en) wp <= ~wp;
            if (rd_en) rp <= ~rp;
            occ <= occ + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

    always_ff @(posedge rdclk) begin
        if (wr_en) mem[wp] <= wr_data;
    end

    assign valid   = occ != 2'd0;
    assign rd_data = valid ? mem[rp] : '0;

endmodule

// File: rtl/gigerx_frame_rd_ctrl.sv
// gigerx_frame_rd_ctrl: pops a byte-count entry, then its data words, and emits a framed stream.
// Define GIGERX_RDCTRL_STATS_EN to add the frm_cnt/drop_cnt statistics outputs.
module gigerx_frame_rd_ctrl
    import gigerx_pkg::*;
#(
    parameter int DWIDTH    = 64,
    parameter int BCWIDTH   = 16,
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic              rdclk,
    input  logic              reset,
    input  logic              bcnt_empty,
    input  logic [BCWIDTH-1:0] bcnt_q,
    output logic              bcnt_rdreq,
    input  logic              dat_empty,
    input  logic [DWIDTH-1:0] dat_q,
    output logic              dat_rdreq,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        out_mod,
    output logic              busy
`ifdef GIGERX_RDCTRL_STATS_EN
    ,
    output logic [31:0]       frm_cnt,
    output logic [31:0]       drop_cnt
`endif
);

    localparam logic [BC_LEN_MSB:0] MAXB = (BC_LEN_MSB+1)'(MAX_BYTES);

    rd_state_e           state;
    rd_state_e           state_nxt;
    logic [WCNT_W-1:0]   cnt;
    logic [WCNT_W-1:0]   wtot;
    logic [2:0]          bmod;
    logic                pend;
    logic                psop;
    logic                peop;
    logic [2:0]          pmod;
    logic [1:0]          occ;
    logic [2:0]          lvl;
    logic                xfer;
    logic                room;
    logic [BC_LEN_MSB:0] bytes;
    logic                bc_bad;
    logic                unused_rsvd;

    assign bytes       = bcnt_q[BC_LEN_MSB:0];
    assign bc_bad      = bcnt_q[BC_ERR_BIT] || bytes > MAXB;
    assign unused_rsvd = bcnt_q[BC_LEN_MSB+1];
    assign xfer        = out_valid && out_ready;
    // the word leaving this cycle frees its slot, which keeps 1 word/cycle in steady state
    assign lvl         = {1'b0, occ} + {2'b0, pend} - {2'b0, xfer};
    assign room        = lvl < 3'd2;
    assign busy        = state != IDLE || out_valid || pend;

    always_comb begin
        state_nxt  = state;
        bcnt_rdreq = 1'b0;
        dat_rdreq  = 1'b0;
        case (state)
            IDLE: begin
                bcnt_rdreq = !bcnt_empty;
                state_nxt  = bcnt_empty ? IDLE : BCNT;
            end
            BCNT: state_nxt = bytes == '0 ? IDLE : bc_bad ? DROP : DATA;
            DATA: begin
                dat_rdreq = !dat_empty && room;
                state_nxt = dat_rdreq && cnt == WCNT_W'(1) ? IDLE : DATA;
            end
            DROP: begin
                dat_rdreq = !dat_empty;
                state_nxt = dat_rdreq && cnt == WCNT_W'(1) ? IDLE : DROP;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            bcnt_rdreq = 1'b0;
            dat_rdreq  = 1'b0;
        end
    end

    always_ff @(posedge rdclk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            wtot  <= '0;
            bmod  <= 3'd0;
            pend  <= 1'b0;
            psop  <= 1'b0;
            peop  <= 1'b0;
            pmod  <= 3'd0;
        end else begin
            state <= state_nxt;
            // frame tags travel alongside the read so they meet the word one cycle later
            pend  <= dat_rdreq && state == DATA;
            psop  <= cnt == wtot;
            peop  <= cnt == WCNT_W'(1);
            pmod  <= cnt == WCNT_W'(1) ? bmod : 3'd0;
            if (state == BCNT) begin
                cnt  <= bc_words(bytes);
                wtot <= bc_words(bytes);
                bmod <= bytes[2:0];
            end else if (dat_rdreq) begin
                cnt <= cnt - WCNT_W'(1);
            end
        end
    end

    gigerx_rdctrl_obuf #(.W(DWIDTH + 5)) u_obuf (
        .rdclk   (rdclk),
        .reset   (reset),
        .wr_en   (pend),
        .wr_data ({dat_q, psop, peop, pmod}),
        .rd_en   (xfer),
        .rd_data ({out_data, out_sop, out_eop, out_mod}),
        .valid   (out_valid),
        .occ     (occ)
    );

`ifdef GIGERX_RDCTRL_STATS_EN
    always_ff @(posedge rdclk) begin
        if (reset) begin
            frm_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (xfer && out_eop) frm_cnt <= frm_cnt + 32'd1;
            if (state == BCNT && (bytes == '0 || bc_bad)) drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule
